// File: rtl/block_stream_gen_if.sv
// rtl/block_stream_gen_if.sv - token input and character output bundle for block_stream_gen
//
// Ports carried:
//   tok_valid/tok_ready  token handshake (producer -> block)
//   tok_type             00 BEGIN, 01 END, 10 SPACE, 11 FILLER
//   tok_upper            uppercase keyword letters (BEGIN/END only)
//   tok_char             byte emitted verbatim for FILLER
//   out_valid/out_char   one ASCII character per cycle, out_char=00 when idle
// modport master: token producer / stream consumer side
// modport slave:  the serializer itself
interface block_stream_gen_if;
    logic       tok_valid;
    logic       tok_ready;
    logic [1:0] tok_type;
    logic       tok_upper;
    logic [7:0] tok_char;
    logic       out_valid;
    logic [7:0] out_char;

    modport master (
        output tok_valid, tok_type, tok_upper, tok_char,
        input  tok_ready, out_valid, out_char
    );

    modport slave (
        input  tok_valid, tok_type, tok_upper, tok_char,
        output tok_ready, out_valid, out_char
    );
endinterface

// File: rtl/block_stream_gen.sv
// rtl/block_stream_gen.sv - token-to-character serializer with nesting depth tracking
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset, aborts any token in flight
//   bus        block_stream_gen_if.slave (token handshake in, character stream out)
//   depth      nesting depth of the emitted stream, saturating at all-ones
//   underflow  sticky flag: an END was accepted at depth 0
//   balanced   depth==0 and no underflow seen
module block_stream_gen #(
    parameter int DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    block_stream_gen_if.slave  bus,
    output logic [DEPTH_W-1:0] depth,
    output logic               underflow,
    output logic               balanced
);
    localparam logic [1:0] T_BEGIN  = 2'b00;
    localparam logic [1:0] T_END    = 2'b01;
    localparam logic [1:0] T_SPACE  = 2'b10;
    localparam logic [1:0] T_FILLER = 2'b11;

    localparam logic [DEPTH_W-1:0] DEPTH_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};

    typedef enum logic [1:0] {IDLE, EMIT, SEP} state_t;

    state_t     state, state_n;
    logic [2:0] idx, idx_n;
    logic [1:0] type_q;
    logic       upper_q;
    logic [7:0] char_q;
    logic       out_valid_q, out_valid_n;
    logic [7:0] out_char_q, out_char_n;
    logic       accept;

    // Character i of the token; FILLER returns its byte, SPACE a blank.
    function automatic logic [7:0] tok_letter(input logic [1:0] t, input logic up,
                                              input logic [7:0] fch, input logic [2:0] i);
        logic [7:0] c;
        c = fch;
        if (t == T_BEGIN) begin
            case (i)
                3'd0:    c = 8'h62;
                3'd1:    c = 8'h65;
                3'd2:    c = 8'h67;
                3'd3:    c = 8'h69;
                default: c = 8'h6E;
            endcase
        end else if (t == T_END) begin
            case (i)
                3'd0:    c = 8'h65;
                3'd1:    c = 8'h6E;
                default: c = 8'h64;
            endcase
        end else if (t == T_SPACE) begin
            c = 8'h20;
        end
        if (up && (t == T_BEGIN || t == T_END))
            c = c - 8'h20;
        return c;
    endfunction

    function automatic logic [2:0] last_idx(input logic [1:0] t);
        case (t)
            T_BEGIN: return 3'd4;
            T_END:   return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    assign bus.tok_ready = (state == IDLE) && !reset;
    assign accept        = bus.tok_valid && bus.tok_ready;

    // The output register is loaded with the character belonging to the
    // state being entered, so the first letter shows the cycle after accept.
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        out_valid_n = 1'b0;
        out_char_n  = 8'h00;
        case (state)
            IDLE: begin
                if (accept) begin
                    idx_n       = 3'd0;
                    out_valid_n = 1'b1;
                    if (bus.tok_type == T_SPACE) begin
                        state_n    = SEP;
                        out_char_n = 8'h20;
                    end else begin
                        state_n    = EMIT;
                        out_char_n = tok_letter(bus.tok_type, bus.tok_upper, bus.tok_char, 3'd0);
                    end
                end
            end
            EMIT: begin
                if (idx == last_idx(type_q)) begin
                    if (type_q == T_FILLER) begin
                        state_n = IDLE;
                    end else begin
                        state_n     = SEP;
                        out_valid_n = 1'b1;
                        out_char_n  = 8'h20;
                    end
                end else begin
                    idx_n       = idx + 3'd1;
                    out_valid_n = 1'b1;
                    out_char_n  = tok_letter(type_q, upper_q, char_q, idx + 3'd1);
                end
            end
            SEP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= 3'd0;
            type_q      <= T_BEGIN;
            upper_q     <= 1'b0;
            char_q      <= 8'h00;
            out_valid_q <= 1'b0;
            out_char_q  <= 8'h00;
            depth       <= '0;
            underflow   <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            out_valid_q <= out_valid_n;
            out_char_q  <= out_char_n;
            if (accept) begin
                type_q  <= bus.tok_type;
                upper_q <= bus.tok_upper;
                char_q  <= bus.tok_char;
                // Depth follows accepted tokens, not the bytes on the wire.
                if (bus.tok_type == T_BEGIN) begin
                    if (depth != DEPTH_MAX)
                        depth <= depth + DEPTH_ONE;
                end else if (bus.tok_type == T_END) begin
                    if (depth != '0)
                        depth <= depth - DEPTH_ONE;
                    else
                        underflow <= 1'b1;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_char  = out_char_q;
    assign balanced      = (depth == '0) && !underflow;
endmodule

// File: tb/tb_block_stream_gen.sv
// tb/tb_block_stream_gen.sv - scoreboard bench for block_stream_gen
module tb_block_stream_gen;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] depth;
    logic       underflow;
    logic       balanced;

    always #5 clk = ~clk;

    block_stream_gen_if bus();

    block_stream_gen #(.DEPTH_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .depth     (depth),
        .underflow (underflow),
        .balanced  (balanced)
    );

    typedef struct {
        logic [7:0] ch;
        int         cy;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   free_cyc = 0;
    int   m_depth = 0;
    bit   m_uf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Stream monitor: every valid character must be the next one queued,
    // in exactly the cycle the model predicted.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset) begin
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_char", {24'h0, bus.out_char}, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("out_char", {24'h0, bus.out_char}, {24'h0, e.ch});
                    chk("out_cycle", cyc, e.cy);
                end
            end else begin
                chk("idle_char", {24'h0, bus.out_char}, 32'h0);
            end
        end
    end

    task automatic reset_pulse();
        reset = 1'b1;
        bus.tok_valid = 1'b0;
        @(negedge clk);
        chk("ready_in_reset", {31'h0, bus.tok_ready}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        free_cyc = cyc + 1;
        m_depth = 0;
        m_uf = 1'b0;
    endtask

    task automatic send_tok(input logic [1:0] t, input logic up, input logic [7:0] c);
        string s;
        int    first;
        @(negedge clk);
        #1;
        first = (cyc + 1 > free_cyc) ? cyc + 1 : free_cyc;
        bus.tok_valid = 1'b1;
        bus.tok_type  = t;
        bus.tok_upper = up;
        bus.tok_char  = c;
        while (cyc + 1 < first) begin
            @(negedge clk);
            #1;
        end
        chk("tok_ready", {31'h0, bus.tok_ready}, 32'h1);
        if (t == 2'b00) begin
            if (up) s = "BEGIN "; else s = "begin ";
        end else if (t == 2'b01) begin
            if (up) s = "END "; else s = "end ";
        end else if (t == 2'b10) begin
            s = " ";
        end else begin
            s = "";
        end
        if (t == 2'b11) begin
            q.push_back('{ch: c, cy: first});
            free_cyc = first + 2;
        end else begin
            for (int i = 0; i < s.len(); i++)
                q.push_back('{ch: s[i], cy: first + i});
            free_cyc = first + s.len() + 1;
        end
        if (t == 2'b00) begin
            if (m_depth < 255) m_depth++;
        end else if (t == 2'b01) begin
            if (m_depth > 0) m_depth--; else m_uf = 1'b1;
        end
        @(posedge clk);
        #1;
        // Scramble the token inputs: the block must use its latched copy.
        bus.tok_valid = 1'b0;
        bus.tok_type  = ~t;
        bus.tok_upper = ~up;
        bus.tok_char  = ~c;
        @(negedge clk);
        chk("depth", {24'h0, depth}, m_depth);
        chk("underflow", {31'h0, underflow}, {31'h0, m_uf});
        chk("balanced", {31'h0, balanced}, {31'h0, (m_depth == 0 && !m_uf)});
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++)
            @(negedge clk);
        chk("drained", q.size(), 0);
    endtask

    initial begin
        bus.tok_valid = 1'b0;
        bus.tok_type  = 2'b00;
        bus.tok_upper = 1'b0;
        bus.tok_char  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset_pulse();
        @(negedge clk);
        chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("rst_depth", {24'h0, depth}, 32'h0);
        chk("rst_underflow", {31'h0, underflow}, 32'h0);
        chk("rst_balanced", {31'h0, balanced}, 32'h1);
        chk("rst_ready", {31'h0, bus.tok_ready}, 32'h1);

        // lowercase BEGIN, then a second token to prove the single idle gap
        send_tok(2'b00, 1'b0, 8'h00);
        send_tok(2'b10, 1'b0, 8'h00);
        drain();

        // "BEGIN END " with a SPACE token after
        reset_pulse();
        send_tok(2'b00, 1'b1, 8'h00);
        send_tok(2'b01, 1'b1, 8'h00);
        send_tok(2'b10, 1'b1, 8'h00);
        drain();

        // END from reset: sticky underflow survives rebalancing
        reset_pulse();
        send_tok(2'b01, 1'b0, 8'h00);
        send_tok(2'b00, 1'b0, 8'h00);
        send_tok(2'b11, 1'b0, 8'h62);
        send_tok(2'b01, 1'b0, 8'h00);
        drain();

        // FILLER glued onto a keyword
        reset_pulse();
        send_tok(2'b11, 1'b0, 8'h78);
        send_tok(2'b00, 1'b0, 8'h00);
        drain();

        // BEGIN held pending through an END's emission
        reset_pulse();
        send_tok(2'b01, 1'b1, 8'h00);
        send_tok(2'b00, 1'b0, 8'h00);
        drain();

        // reset during the 3rd character of BEGIN
        reset_pulse();
        send_tok(2'b00, 1'b0, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_pulse();
        @(negedge clk);
        chk("mid_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("mid_out_char", {24'h0, bus.out_char}, 32'h0);
        chk("mid_depth", {24'h0, depth}, 32'h0);
        chk("mid_ready", {31'h0, bus.tok_ready}, 32'h1);

        // depth saturation
        for (int i = 0; i < 256; i++)
            send_tok(2'b00, 1'($urandom_range(0, 1)), 8'h00);
        chk("sat_depth", {24'h0, depth}, 32'd255);
        send_tok(2'b01, 1'b0, 8'h00);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/block_stream_gen.md
Name: block_stream_gen

Overview:
- Token-to-character serializer that produces the ASCII stream consumed by the begin/end block checker.
- Accepts one token per handshake: BEGIN, END, SPACE or a literal FILLER byte.
- Emits one character per cycle on an 8-bit output.
- Tracks nesting depth of the emitted stream and flags END-without-BEGIN, so benches can drive the checker and know the expected result.

Parameters:
- DEPTH_W, 8, width of the nesting-depth counter; the counter saturates at 2^DEPTH_W-1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- tok_valid  input  1  token present
- tok_ready  output  1  block can accept a token this cycle
- tok_type  input  2  00 BEGIN, 01 END, 10 SPACE, 11 FILLER
- tok_upper  input  1  emit keyword letters in uppercase (BEGIN/END only)
- tok_char  input  8  byte emitted for FILLER; ignored otherwise
- out_valid  output  1  out_char carries a stream character this cycle
- out_char  output  8  ASCII character; 8'h00 when out_valid=0
- depth  output  DEPTH_W  current nesting depth of the emitted stream
- underflow  output  1  sticky: an END was accepted at depth 0
- balanced  output  1  depth==0 && !underflow

Behaviour:
- Reset (sync, highest priority, also mid-token) takes effect at the next edge:
  - state=IDLE, out_valid=0, out_char=8'h00, depth=0, underflow=0.
  - Any partially emitted token is discarded.
- State machine has three states: IDLE, EMIT, SEP.
  - tok_ready = (state==IDLE) && !reset.
  - Accept = tok_valid && tok_ready at a rising edge.
  - tok_type, tok_upper and tok_char are latched at accept; later changes to these inputs are ignored until the next accept.
- Output is registered. The first character is on out_char during the cycle after accept. One character is emitted per cycle, with no stalls.
- Token emission:
  - BEGIN: state EMIT, 5 cycles, "begin" (or "BEGIN" if upper); then SEP, 1 cycle, " "; total 6 cycles.
  - END: state EMIT, 3 cycles, "end" (or "END"); then SEP, 1 cycle, " "; total 4 cycles.
  - SPACE: SEP only, 1 cycle, " ".
  - FILLER: EMIT, 1 cycle, tok_char verbatim. No trailing space, so FILLER can glue onto a keyword to form a non-keyword word.
- A 3-bit character index selects the next keyword letter. It resets to 0 at accept.
- After the last character of a token the state returns to IDLE. In that IDLE cycle out_valid=0, tok_ready=1. Every token is therefore followed by exactly one idle cycle.
- Depth and underflow update at the accept edge, not at end of emission:
  - BEGIN: depth+1, saturating at all-ones.
  - END with depth>0: depth-1.
  - END with depth==0: depth stays 0, underflow<=1. underflow clears only on reset.
  - SPACE and FILLER: no change, even if the FILLER byte spells a keyword letter.
- balanced is combinational from the registered depth and underflow.
- tok_valid while tok_ready=0 is ignored. No token is queued; the producer holds tok_valid until accepted.

Test Plan:
1. Reset, then BEGIN with tok_upper=0 → out_char 62,65,67,69,6E,20 (hex) on 6 consecutive cycles starting 1 cycle after accept. Then one cycle with out_valid=0, tok_ready=1. depth=1, balanced=0.
2. BEGIN, END, both with tok_upper=1 → stream "BEGIN END ". depth goes 1 then 0; balanced=1, underflow=0.
3. END from reset → "end " emitted, depth=0, underflow=1, balanced=0. Then BEGIN, END → depth returns to 0 but balanced stays 0 until reset.
4. FILLER 'x', then BEGIN → stream "xbegin ". depth=1 (depth counts accepted tokens, not checker semantics).
5. Hold tok_valid with a BEGIN during an END's emission → no accept until the IDLE cycle; the second token's first character appears exactly 1 cycle after that.
6. Assert reset on the 3rd character of BEGIN → the next cycle has out_valid=0, out_char=00, depth=0, tok_ready=1. Assert 256 BEGINs with DEPTH_W=8 → depth saturates at 255.
